serial_add_ctrl: RTL



---
 rtl/serial_add_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: drives one external full-adder cell a bit per clock, LSB first.
// Optional two's-complement overflow output is enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_c,
  input  logic             fa_sum,
  input  logic             fa_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
`ifdef SERIAL_ADD_OVF_EN
  output logic             ovf,
`endif
  output logic             cout_out
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // Holds the sum bits collected so far, top-aligned; the final bit comes
  // straight from fa_sum on the last edge, so only WIDTH-1 bits are stored.
  logic [WIDTH-2:0] sum_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             last_bit;

  assign last_bit = (cnt == LAST);

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of this block is given a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    fa_a       = 1'b0;
    fa_b       = 1'b0;
    fa_c       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_SHIFT;
      end
      S_SHIFT: begin
        busy = 1'b1;
        fa_a = a_sh[0];
        fa_b = b_sh[0];
        fa_c = carry;
        if (last_bit) state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh     <= '0;
      b_sh     <= '0;
      sum_sh   <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      sum_out  <= '0;
      cout_out <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf      <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sh   <= a_in;
            b_sh   <= b_in;
            carry  <= cin;
            cnt    <= '0;
            sum_sh <= '0;
          end
        end
        S_SHIFT: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= (sum_sh >> 1) | ((WIDTH-1)'(fa_sum) << (WIDTH - 2));
          carry  <= fa_cout;
          if (last_bit) begin
            sum_out  <= {fa_sum, sum_sh};
            cout_out <= fa_cout;
`ifdef SERIAL_ADD_OVF_EN
            // carry still holds the carry into the MSB during the last bit.
            ovf      <= carry ^ fa_cout;
`endif
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
